// File: rtl/pooled_map_pkg.sv
// Shared types and sizing helpers for the pooled feature-map buffer.
// Defaults match the 12x12 map produced by the 2x2 pooling layer.
package pooled_map_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int WINDOWS_DEF    = 12;
  localparam int COLUMNS_DEF    = 12;

  typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MAP_SIZE_DEF = WINDOWS_DEF * COLUMNS_DEF;
  localparam int ROW_W_DEF    = cnt_w(WINDOWS_DEF);
  localparam int COL_W_DEF    = cnt_w(COLUMNS_DEF);

endpackage

// File: rtl/pooled_map_buffer_drain.sv
// Column-major read position for the drain side of the map buffer.
// Row advances fastest; the whole counter wraps after the final element.
module map_drain_counter
  import pooled_map_pkg::*;
#(
  parameter int WINDOWS = WINDOWS_DEF,
  parameter int COLUMNS = COLUMNS_DEF,
  parameter int ROW_W   = cnt_w(WINDOWS),
  parameter int COL_W   = cnt_w(COLUMNS)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] rd_row,
  output logic [COL_W-1:0] rd_col,
  output logic             last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             row_end;

  assign row_end = (row_q == ROW_W'(WINDOWS - 1));
  assign last    = row_end && (col_q == COL_W'(COLUMNS - 1));
  assign rd_row  = row_q;
  assign rd_col  = col_q;

  // Next read position: step row, carry into column, wrap after last.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (row_end) begin
        row_d = '0;
        col_d = last ? '0 : col_q + COL_W'(1);
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  // Position register; clearing is folded into the next-state logic.
  always_ff @(posedge clk) begin
    row_q <= row_d;
    col_q <= col_d;
  end

endmodule

// File: rtl/pooled_map_buffer.sv
// Ping-pong feature-map buffer between the pooling layer and the FC stage.
// Columns arrive unthrottled; elements leave column-major via valid/ready.
module pooled_map_buffer
  import pooled_map_pkg::*;
#(
  parameter int WINDOWS    = WINDOWS_DEF,
  parameter int COLUMNS    = COLUMNS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [WINDOWS*DATA_WIDTH-1:0] input_column,
  output logic                          in_ready,
  output logic                          overflow,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  input  logic                          out_ready
);

  localparam int ROW_W    = cnt_w(WINDOWS);
  localparam int COL_W    = cnt_w(COLUMNS);
  localparam int COL_BITS = WINDOWS * DATA_WIDTH;

  logic [COL_BITS-1:0] mem_q [2][COLUMNS];
  logic [COL_BITS-1:0] mem_d [2][COLUMNS];

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             drop;
  logic             wr_done;
  logic             xfer;
  logic             rd_last;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [COL_BITS-1:0] rd_word;

  assign in_ready  = !full_q[wr_bank_q];
  assign accept    = valid_in && in_ready;
  assign drop      = valid_in && !in_ready;
  assign wr_done   = accept && (wr_col_q == COL_W'(COLUMNS - 1));
  assign out_valid = full_q[rd_bank_q];
  assign xfer      = out_valid && out_ready;
  assign out_last  = out_valid && rd_last;
  assign overflow  = overflow_q;
  assign rd_word   = mem_q[rd_bank_q][rd_col];
  assign out_data  = out_valid
                   ? rd_word[rd_row*DATA_WIDTH +: DATA_WIDTH]
                   : '0;

  map_drain_counter #(
    .WINDOWS (WINDOWS),
    .COLUMNS (COLUMNS)
  ) u_drain (
    .clk     (clk),
    .clear   (!rst),
    .advance (xfer),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .last    (rd_last)
  );

  // Column store: only the bank/column being filled is overwritten.
  always_comb begin
    mem_d = mem_q;
    if (accept) begin
      mem_d[wr_bank_q][wr_col_q] = input_column;
    end
  end

  // Bank control: fill and drain always target different banks, so a
  // completing write and a finishing drain can both land in one cycle.
  always_comb begin
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    wr_col_d   = wr_col_q;
    overflow_d = overflow_q | drop;
    if (accept) begin
      if (wr_done) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_col_d          = '0;
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end
    if (xfer && rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  // Storage is never cleared; stale data is unreachable once full drops.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      wr_col_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      wr_col_q   <= wr_col_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pooled_map_buffer.sv
// Bench for pooled_map_buffer: vector table, directed sequences and
// random traffic checked every cycle against a queue-based map model.
module tb_pooled_map_buffer;
  import pooled_map_pkg::*;

  localparam int W  = 12;
  localparam int C  = 12;
  localparam int DW = 16;
  localparam int N  = W * C;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_in;
  logic [W*DW-1:0] input_column;
  logic            in_ready;
  logic            overflow;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;

  pooled_map_buffer #(
    .WINDOWS    (W),
    .COLUMNS    (C),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .input_column (input_column),
    .in_ready     (in_ready),
    .overflow     (overflow),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  pixel_t exp_q[$];
  pixel_t part_q[$];
  int     full_cnt;
  int     rd_idx;
  bit     m_ovf;
  int     last_seen;
  pixel_t last_val;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W*DW-1:0] mkcol(input int base);
    logic [W*DW-1:0] col;
    for (int r = 0; r < W; r++) col[r*DW +: DW] = DW'(base + r);
    return col;
  endfunction

  function automatic logic [W*DW-1:0] rndcol();
    logic [W*DW-1:0] col;
    for (int r = 0; r < W; r++) col[r*DW +: DW] = DW'($urandom);
    return col;
  endfunction

  // Map model: queue of pending complete-map elements in output order.
  task automatic model_step();
    bit v;
    bit rdy;
    int fc;
    if (!rst) begin
      exp_q.delete();
      part_q.delete();
      full_cnt = 0;
      rd_idx   = 0;
      m_ovf    = 1'b0;
      return;
    end
    v   = full_cnt > 0;
    rdy = full_cnt < 2;
    fc  = full_cnt;
    if (v && out_ready) begin
      void'(exp_q.pop_front());
      rd_idx++;
      if (rd_idx == N) begin
        rd_idx = 0;
        fc--;
      end
    end
    if (valid_in) begin
      if (rdy) begin
        for (int r = 0; r < W; r++) part_q.push_back(input_column[r*DW +: DW]);
        if (part_q.size() == N) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          fc++;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    full_cnt = fc;
  endtask

  task automatic check_model();
    bit v;
    v = full_cnt > 0;
    chk("in_ready", in_ready, full_cnt < 2);
    chk("out_valid", out_valid, v);
    chk("out_data", out_data, v ? exp_q[0] : '0);
    chk("out_last", out_last, v && (rd_idx == N - 1));
    chk("overflow", overflow, m_ovf);
    if (out_valid && out_last) begin
      last_seen++;
      last_val = out_data;
    end
  endtask

  task automatic cyc(input logic r, input logic v,
                     input logic [W*DW-1:0] col, input logic o);
    rst          = r;
    valid_in     = v;
    input_column = col;
    out_ready    = o;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic        vin;
    int          base;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        e_last;
    logic        e_of;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl[16];

  initial begin
    for (int i = 0; i < 12; i++)
      tbl[i] = '{1'b1, i * 16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[12] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[13] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001};
    tbl[14] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002};
    tbl[15] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0003};

    rst = 1'b0; valid_in = 1'b0; input_column = '0; out_ready = 1'b0;
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // Fill/drain, first cycles against the hand-written table.
    last_seen = 0;
    for (int i = 0; i < 16; i++) begin
      chk("tbl_in_ready", in_ready, tbl[i].e_ir);
      chk("tbl_out_valid", out_valid, tbl[i].e_ov);
      chk("tbl_out_data", out_data, tbl[i].e_data);
      chk("tbl_out_last", out_last, tbl[i].e_last);
      chk("tbl_overflow", overflow, tbl[i].e_of);
      cyc(1'b1, tbl[i].vin, mkcol(tbl[i].base), tbl[i].ordy);
    end
    for (int i = 0; i < 142; i++) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("fill_last_count", last_seen, 1);
    chk("fill_last_value", last_val, 16'h00BB);
    chk("fill_drained", out_valid, 1'b0);

    // Backpressure: ready pattern 1,0,0 repeating.
    for (int c = 0; c < C; c++) cyc(1'b1, 1'b1, mkcol(c * 16), 1'b0);
    for (int i = 0; i < 450; i++) cyc(1'b1, 1'b0, '0, (i % 3) == 0);
    chk("bp_drained", out_valid, 1'b0);

    // Ping-pong: two maps back to back.
    for (int c = 0; c < 2 * C; c++)
      cyc(1'b1, 1'b1, mkcol((c / C) * 256 + (c % C) * 16), 1'b1);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("pp_overflow", overflow, 1'b0);

    // Overflow: third map's first column dropped while both banks full.
    for (int c = 0; c < 2 * C; c++)
      cyc(1'b1, 1'b1, mkcol((c / C) * 256 + (c % C) * 16), 1'b0);
    chk("ovf_in_ready", in_ready, 1'b0);
    cyc(1'b1, 1'b1, mkcol(16'h0EEE), 1'b0);
    chk("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("ovf_sticky", overflow, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("ovf_cleared", overflow, 1'b0);

    // Reset mid-drain.
    for (int c = 0; c < C; c++) cyc(1'b1, 1'b1, mkcol(c * 16), 1'b0);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    for (int c = 0; c < C; c++)
      cyc(1'b1, 1'b1, mkcol(16'h0200 + c * 16), 1'b0);
    chk("rst_new_first", out_data, 16'h0200);
    for (int i = 0; i < 160; i++) cyc(1'b1, 1'b0, '0, 1'b1);

    // Partial fill abandoned by reset.
    for (int c = 0; c < 5; c++)
      cyc(1'b1, 1'b1, mkcol(16'h0300 + c * 16), 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    for (int c = 0; c < C; c++)
      cyc(1'b1, 1'b1, mkcol(16'h0400 + c * 16), 1'b1);
    chk("part_first", out_data, 16'h0400);
    for (int i = 0; i < 160; i++) cyc(1'b1, 1'b0, '0, 1'b1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      logic r;
      logic v;
      logic o;
      r = $urandom_range(0, 999) != 0;
      v = (i % 1000) < 500 ? $urandom_range(0, 2) == 0
                           : $urandom_range(0, 15) == 0;
      o = $urandom_range(0, 3) != 0;
      cyc(r, v, rndcol(), o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pooled_map_buffer.md
Name: pooled_map_buffer

Overview:
- Sits directly downstream of the 2x2 pooling layer.
- Collects the pooled output columns (WINDOWS values per column) into a complete COLUMNS x WINDOWS feature map.
- Streams the map out one element per handshake to the fully connected stage, in column-major order.
- Double-buffered (ping-pong) so the pooling stage, which has no backpressure, can write the next map while the previous one drains.

Parameters:
- WINDOWS, 12, values per incoming column (rows of the pooled map).
- COLUMNS, 12, columns per feature map.
- DATA_WIDTH, 16, bits per element.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- valid_in  in  1  input_column valid for this cycle (single-cycle pulse per column from the pooling stage).
- input_column  in  WINDOWS x DATA_WIDTH  pooled column; index r = row r.
- in_ready  out  1  a write bank is free; informational only, the upstream stage cannot stall.
- overflow  out  1  sticky: a column arrived while in_ready=0.
- out_valid  out  1  an element of a full bank is presented.
- out_data  out  DATA_WIDTH  current element.
- out_last  out  1  current element is the final one of the map (index WINDOWS*COLUMNS-1).
- out_ready  in  1  downstream accepts out_data this cycle.

Behaviour:
- Storage: two banks of COLUMNS x WINDOWS registers. Control state:
  - wr_bank, rd_bank (1 bit each).
  - full[1:0].
  - wr_col (0..COLUMNS-1).
  - rd_col (0..COLUMNS-1), rd_row (0..WINDOWS-1).
- Reset (rst=0 at posedge): wr_bank=rd_bank=0, full=0, all counters 0, overflow=0. Storage is not cleared. Outputs after reset: in_ready=1, out_valid=0, out_data=0, out_last=0.
- in_ready = !full[wr_bank] (combinational).
- Write path, when valid_in && in_ready:
  - Store input_column into bank wr_bank, column wr_col.
  - If wr_col==COLUMNS-1: full[wr_bank]<=1, wr_bank toggles, wr_col<=0.
  - Otherwise wr_col++.
- Drop: valid_in && !in_ready -> column discarded, overflow<=1, no other state change. overflow clears only on reset.
- Read path:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][rd_col][rd_row] when out_valid, else 0.
  - out_last = out_valid && rd_col==COLUMNS-1 && rd_row==WINDOWS-1.
  - Element order: index = rd_col*WINDOWS + rd_row, i.e. row increments fastest.
- Handshake: a transfer occurs on out_valid && out_ready.
  - On transfer, rd_row++. At rd_row==WINDOWS-1 it wraps to 0 and rd_col++.
  - On the out_last transfer: full[rd_bank]<=0, rd_bank toggles, counters<=0.
  - While out_valid && !out_ready, out_data/out_last hold stable.
  - out_ready while !out_valid is ignored.
- Latency: the cycle after the final column of a map is accepted, out_valid=1 with element 0. With out_ready held high, 144 consecutive transfers (default parameters).
- Simultaneous events:
  - Completing a write bank and finishing a drain in the same cycle touch different banks. Both updates apply.
  - When both banks are full, in_ready=0. A drain finishing in that cycle frees its bank from the next cycle only; a column in that same cycle is dropped.
- Reset mid-fill or mid-drain: the partial or pending map is abandoned. Out_valid drops on the cycle after reset is sampled, and the first column after reset goes to bank 0, column 0.

Decomposition:
- Package pooled_map_pkg holds:
  - DATA_WIDTH default.
  - typedef pixel_t (logic [DATA_WIDTH-1:0]).
  - Localparam helpers for the map size (WINDOWS*COLUMNS) and counter widths ($clog2).
- Sub-module map_drain_counter: rd_row/rd_col counter with advance and clear inputs and a last output. The top level holds the banks, the write logic and the full flags.

Test Plan:
- Fill/drain: 12 columns, column c row r = c*16+r, out_ready=1 -> 144 outputs in order 0,1,...,11,16,...; out_last only on value 0xBB; out_valid falls the next cycle; overflow=0.
- Backpressure: same map, out_ready toggling 1,0,0,1,... -> out_data stable during stalls, the 144-value sequence is unchanged, no duplicates or skips.
- Ping-pong: 24 back-to-back columns (two maps, second map values +0x100), out_ready=1 -> both maps emitted in order; in_ready never 0 on a valid_in cycle; overflow=0.
- Overflow: out_ready=0, 25 columns -> first 24 accepted; in_ready=0 after the 24th; the 25th sets overflow=1. Then out_ready=1 -> map 1 then map 2 intact, and overflow stays 1.
- Reset mid-drain: fill 12 columns, accept 50 elements, pulse rst=0 for one cycle -> out_valid=0, in_ready=1. A new map of 12 columns drains from element 0 with the new values.
- Partial fill reset: 5 columns, reset, then 12 columns of new data -> output contains only the new data, no stale columns.
